// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the instruction loader: FSM encoding, frame header, store geometry.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHK   = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;
  localparam int         DEPTH_DEF  = 64;
  localparam int         ADDR_W_DEF = 6;

endpackage

// File: rtl/instr_loader_ram.sv
// Instruction store: DEPTH x 16, synchronous write, zero-latency asynchronous read.
// No reset on the array; stale words are masked by the loader, not cleared.
module instr_ram
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream loader into the instruction store; holds the CPU in reset until a checksummed image is resident.
// Fetch is combinational; rx_ready drops only in RUN unless INSTR_LOADER_RELOAD_EN allows a new header there.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int         DEPTH  = DEPTH_DEF,
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [7:0] HDR    = HDR_BYTE
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] PC,
  output logic [15:0]       InstructOut,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  state_t            state_q, state_d;
  // One extra bit so a full-depth frame's final address does not wrap to zero.
  logic [ADDR_W:0]   addr_q, addr_d, count_q, count_d, wv_q, wv_d, addr_inc;
  logic [7:0]        chk_q, chk_d, hi_q, hi_d;
  logic              crst_q, crst_d, done_q, done_d, err_q, err_d;
  logic              we;
  logic [15:0]       rdata;

  assign addr_inc = addr_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wv_d    = wv_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    crst_d  = crst_q;
    done_d  = done_q;
    err_d   = err_q;
    we      = 1'b0;
`ifdef INSTR_LOADER_RELOAD_EN
    rx_ready = 1'b1;
`else
    rx_ready = (state_q != S_RUN);
`endif
    if (rx_valid && rx_ready) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == HDR) begin
            state_d = S_COUNT;
            err_d   = 1'b0;
            addr_d  = '0;
            chk_d   = '0;
            wv_d    = '0;
          end
        end
        S_COUNT: begin
          if (rx_data == 8'h00 || {1'b0, rx_data} > DEPTH_B) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            count_d = rx_data[ADDR_W:0];
            state_d = S_HI;
          end
        end
        S_HI: begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_LO;
        end
        S_LO: begin
          we      = 1'b1;
          chk_d   = chk_q ^ rx_data;
          addr_d  = addr_inc;
          state_d = (addr_inc == count_q) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (rx_data == chk_q) begin
            state_d = S_RUN;
            wv_d    = count_q;
            crst_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_RUN: begin
`ifdef INSTR_LOADER_RELOAD_EN
          // A new header invalidates the running image and re-enters the header path directly.
          if (rx_data == HDR) begin
            crst_d  = 1'b1;
            done_d  = 1'b0;
            state_d = S_COUNT;
            err_d   = 1'b0;
            addr_d  = '0;
            chk_d   = '0;
            wv_d    = '0;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wv_q    <= '0;
      chk_q   <= '0;
      hi_q    <= '0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wv_q    <= wv_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  instr_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk_main),
    .we    (we),
    .waddr (addr_q[ADDR_W-1:0]),
    .wdata ({hi_q, rx_data}),
    .raddr (PC),
    .rdata (rdata)
  );

  assign InstructOut = ({1'b0, PC} < wv_q) ? rdata : 16'h0000;
  assign cpu_reset   = crst_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule
